// File: rtl/ts_packet_arbiter.sv
// ---------------------------------------------------------------------------
// ts_packet_arbiter
//
// Packet-level round-robin scheduler merging four MPEG-2 TS byte streams
// (read side of the per-channel FIFOs, 100 MHz domain) into one byte stream.
// A channel is granted for exactly one PKT_LEN-byte packet. It is granted
// only when its head byte is SYNC_BYTE. While idle, channels whose head
// byte is not SYNC_BYTE are drained ("hunting"), and every drained byte is
// counted in a saturating per-channel drop counter.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, a granted packet whose source stalls for TIMEOUT_CYCLES
//   cycles is truncated. out_abort pulses and the arbiter returns to IDLE.
//   When undefined, SEND waits indefinitely and out_abort is tied low.
//
// Ports:
//   clk        in   read-domain clock
//   rst        in   synchronous active-high reset
//   in_data    in   4*DATA_WIDTH, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   in   4, per-channel head byte valid
//   in_ready   out  4, per-channel pop (consumed when in_valid & in_ready)
//   out_data   out  DATA_WIDTH merged byte (0 while not in SEND)
//   out_valid  out  out_data valid
//   out_ready  in   downstream accept
//   out_sop    out  first byte of packet, qualified by out_valid
//   out_eop    out  last byte (PKT_LEN-1) of packet, qualified by out_valid
//   out_chan   out  2, granted channel index
//   out_abort  out  one-cycle pulse: current packet truncated
//   drop_cnt   out  4*CNT_WIDTH, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
// ---------------------------------------------------------------------------
module ts_packet_arbiter #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    PKT_LEN        = 188,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'h47,
    parameter int                    CNT_WIDTH      = 16,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*DATA_WIDTH-1:0] in_data,
    input  logic [3:0]              in_valid,
    output logic [3:0]              in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic [1:0]              out_chan,
    output logic                    out_abort,
    output logic [4*CNT_WIDTH-1:0]  drop_cnt
);

    localparam int                BCNT_W    = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(PKT_LEN - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state;
    logic [1:0]             grant;
    logic [1:0]             last_grant;
    logic [BCNT_W-1:0]      byte_cnt;
    logic [CNT_WIDTH-1:0]   drop_q [4];

    logic [DATA_WIDTH-1:0]  chan_data [4];
    logic [3:0]             eligible;
    logic [3:0]             hunt;
    logic                   pick_found;
    logic [1:0]             pick_idx;
    logic                   accept;
    logic                   timeout_hit;

    // -----------------------------------------------------------------------
    // Input unpacking and per-channel idle classification
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            chan_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        eligible = '0;
        hunt     = '0;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = in_valid[i] && (chan_data[i] == SYNC_BYTE);
            // Drain non-sync head bytes only while idle and out of reset, so
            // a held reset neither pops nor loses uncounted bytes.
            hunt[i]     = (state == IDLE) && !rst && in_valid[i] &&
                          (chan_data[i] != SYNC_BYTE);
        end
    end

    // Round-robin pick: scan last_grant+1, +2, +3, then last_grant itself.
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic [1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign accept = (state == SEND) && in_valid[grant] && out_ready;

    // -----------------------------------------------------------------------
    // Stall timeout (optional)
    // -----------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [STALL_W-1:0] stall_cnt;

    // stall_cnt is k-1 on the k-th consecutive empty cycle, so the abort
    // fires TIMEOUT_CYCLES cycles after the last accepted byte.
    assign timeout_hit = (state == SEND) && !in_valid[grant] &&
                         (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
`else
    // Constant false for every legal (positive) TIMEOUT_CYCLES; referencing
    // the parameter keeps it a live part of the interface in this build.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // -----------------------------------------------------------------------
    // State, grant bookkeeping and drop counters
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd3;     // channel 0 is first in line after reset
            byte_cnt   <= '0;
            // NOTE: the drop counters are four ordinary flop registers, not a
            // RAM, so they are reset like any other state.
            for (int i = 0; i < 4; i++) begin
                drop_q[i] <= '0;
            end
`ifdef ARB_TIMEOUT_EN
            stall_cnt  <= '0;
`endif
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (hunt[i] && (drop_q[i] != '1)) begin
                    drop_q[i] <= drop_q[i] + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        byte_cnt   <= '0;
                        state      <= SEND;
`ifdef ARB_TIMEOUT_EN
                        stall_cnt  <= '0;
`endif
                    end
                end

                SEND: begin
                    if (accept) begin
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    // last_grant is left alone so the next channel is
                    // offered first after a truncated packet.
                    if (accept) begin
                        stall_cnt <= '0;
                    end else if (timeout_hit) begin
                        stall_cnt <= '0;
                        byte_cnt  <= '0;
                        state     <= IDLE;
                    end else if (!in_valid[grant]) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Combinational data path: zero latency in_* -> out_* and
    // out_ready -> in_ready[grant].
    // -----------------------------------------------------------------------
    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        in_ready  = '0;
        if (state == SEND) begin
            out_data        = chan_data[grant];
            out_valid       = in_valid[grant];
            out_sop         = in_valid[grant] && (byte_cnt == '0);
            out_eop         = in_valid[grant] && (byte_cnt == LAST_BYTE);
            in_ready[grant] = out_ready;
        end else begin
            // Hunting never touches an eligible channel, so the channel being
            // granted this cycle is not popped.
            in_ready = hunt;
        end
    end

    assign out_chan  = grant;
    assign out_abort = timeout_hit;

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            drop_cnt[i*CNT_WIDTH +: CNT_WIDTH] = drop_q[i];
        end
    end

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ts_packet_arbiter
//
// Scoreboard bench for ts_packet_arbiter. Each channel source is a byte
// queue whose head drives in_data/in_valid. Bytes are popped when the DUT
// handshakes them. Every byte expected at the output is pushed to the
// scoreboard when loaded and popped when the DUT delivers an output byte.
// ---------------------------------------------------------------------------
module tb_ts_packet_arbiter;

    localparam int DW  = 8;
    localparam int PKT = 188;
    localparam int CW  = 16;
    localparam int TO  = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [1:0] chan;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [4*DW-1:0] in_data = '0;
    logic [3:0]      in_valid = '0;
    logic [3:0]      in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            out_sop;
    logic            out_eop;
    logic [1:0]      out_chan;
    logic            out_abort;
    logic [4*CW-1:0] drop_cnt;

    ts_packet_arbiter #(
        .DATA_WIDTH     (DW),
        .PKT_LEN        (PKT),
        .SYNC_BYTE      (8'h47),
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_chan  (out_chan),
        .out_abort (out_abort),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Sources, scoreboard, bookkeeping
    logic [7:0] ch_q [4][$];
    beat_t      sb [$];
    logic [7:0] pkt [PKT];
    int         sop_cyc [$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fire_total = 0;
    int last_fire_cyc = 0;
    int abort_cnt = 0;
    int abort_gap = 0;
    bit chk_ready = 1'b0;

    // Snapshot of DUT outputs taken at the last falling edge
    logic            s_valid, s_sop, s_eop, s_abort;
    logic [3:0]      s_in_ready;
    logic [1:0]      s_chan;
    logic [DW-1:0]   s_data;
    logic [4*CW-1:0] s_drop;

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            if (ch_q[i].size() > 0) begin
                in_valid[i]         = 1'b1;
                in_data[i*DW +: DW] = ch_q[i][0];
            end else begin
                in_valid[i]         = 1'b0;
                in_data[i*DW +: DW] = '0;
            end
        end
    endtask

    // One clock cycle: sample and score at negedge, pop sources after posedge.
    task automatic tick();
        logic [3:0] pops;
        beat_t      got;
        beat_t      exp;
        @(negedge clk);
        cyc++;
        s_valid    = out_valid;
        s_sop      = out_sop;
        s_eop      = out_eop;
        s_abort    = out_abort;
        s_in_ready = in_ready;
        s_chan     = out_chan;
        s_data     = out_data;
        s_drop     = drop_cnt;
        pops       = in_valid & in_ready;
        if (out_abort === 1'b1) begin
            abort_cnt++;
            abort_gap = cyc - last_fire_cyc;
        end
        if (chk_ready && out_valid === 1'b1) begin
            n_cmp++;
            if (in_ready !== (out_ready ? (4'b0001 << out_chan) : 4'b0000)) begin
                n_bad++;
                $display("FAIL in_ready_mirror: in_ready=%b out_ready=%b chan=%0d", in_ready, out_ready, out_chan);
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got = '{data: out_data, sop: out_sop, eop: out_eop, chan: out_chan};
            fire_total++;
            last_fire_cyc = cyc;
            if (out_sop === 1'b1) sop_cyc.push_back(cyc);
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_byte: got data=%02h chan=%0d with empty scoreboard", out_data, out_chan);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL out_byte: got data=%02h sop=%b eop=%b chan=%0d, expected data=%02h sop=%b eop=%b chan=%0d",
                             got.data, got.sop, got.eop, got.chan, exp.data, exp.sop, exp.eop, exp.chan);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pops[i] && ch_q[i].size() > 0) void'(ch_q[i].pop_front());
        end
        drive_inputs();
    endtask

    task automatic new_packet();
        pkt[0] = 8'h47;
        for (int k = 1; k < PKT; k++) pkt[k] = 8'($urandom);
    endtask

    // Load pkt[lo..hi] into a channel source and the scoreboard.
    task automatic load_range(input int ch, input int lo, input int hi);
        beat_t b;
        for (int k = lo; k <= hi; k++) begin
            ch_q[ch].push_back(pkt[k]);
            b.data = pkt[k];
            b.sop  = (k == 0);
            b.eop  = (k == PKT - 1);
            b.chan = 2'(ch);
            sb.push_back(b);
        end
    endtask

    task automatic reset_on();
        rst       = 1'b1;
        out_ready = 1'b1;
        chk_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) ch_q[i].delete();
        sb.delete();
        sop_cyc.delete();
        abort_cnt = 0;
        drive_inputs();
    endtask

    task automatic release_rst();
        drive_inputs();
        rst = 1'b0;
    endtask

    task automatic run_until_empty(input string name, input int budget, input bit toggle);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            if (toggle) out_ready = ~out_ready;
            tick();
            n++;
        end
        out_ready = 1'b1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d bytes still expected after %0d cycles", name, sb.size(), budget);
            sb.delete();
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        // Sync byte on ch0 and garbage on ch1 while reset is held
        rst = 1'b1;
        ch_q[0].push_back(8'h47);
        ch_q[1].push_back(8'h12);
        drive_inputs();
        tick();
        tick();
        n_cmp++; if (s_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", s_valid); end
        n_cmp++; if (s_sop !== 1'b0)      begin n_bad++; $display("FAIL reset_out_sop: got %b want 0", s_sop); end
        n_cmp++; if (s_eop !== 1'b0)      begin n_bad++; $display("FAIL reset_out_eop: got %b want 0", s_eop); end
        n_cmp++; if (s_abort !== 1'b0)    begin n_bad++; $display("FAIL reset_out_abort: got %b want 0", s_abort); end
        n_cmp++; if (s_in_ready !== 4'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0000", s_in_ready); end
        n_cmp++; if (s_chan !== 2'd0)     begin n_bad++; $display("FAIL reset_out_chan: got %0d want 0", s_chan); end
        n_cmp++; if (s_data !== 8'h00)    begin n_bad++; $display("FAIL reset_out_data: got %02h want 00", s_data); end
        n_cmp++; if (s_drop !== '0)       begin n_bad++; $display("FAIL reset_drop_cnt: got %h want 0", s_drop); end
    endtask

    task automatic test_single_packet();
        reset_on();
        new_packet();
        load_range(0, 0, PKT - 1);
        release_rst();
        run_until_empty("single", 400, 1'b0);
        tick();
        n_cmp++; if (sop_cyc.size() != 1) begin n_bad++; $display("FAIL single_sop_count: got %0d want 1", sop_cyc.size()); end
        n_cmp++; if (s_drop !== '0)      begin n_bad++; $display("FAIL single_drop_cnt: got %h want 0", s_drop); end
    endtask

    task automatic test_round_robin();
        int order [5];
        order = '{0, 1, 2, 3, 0};
        reset_on();
        for (int p = 0; p < 5; p++) begin
            new_packet();
            load_range(order[p], 0, PKT - 1);
        end
        release_rst();
        run_until_empty("round_robin", 5 * (PKT + 1) + 50, 1'b0);
        n_cmp++;
        if (sop_cyc.size() != 5) begin
            n_bad++;
            $display("FAIL rr_sop_count: got %0d want 5", sop_cyc.size());
        end
        for (int i = 1; i < sop_cyc.size(); i++) begin
            n_cmp++;
            if (sop_cyc[i] - sop_cyc[i-1] != PKT + 1) begin
                n_bad++;
                $display("FAIL rr_period_%0d: got %0d cycles want %0d", i, sop_cyc[i] - sop_cyc[i-1], PKT + 1);
            end
        end
    endtask

    task automatic test_hunting();
        logic [7:0] junk [5];
        junk = '{8'h00, 8'h11, 8'hFF, 8'h46, 8'h48};
        reset_on();
        // ch0 is granted on the same cycle ch2's first garbage byte is hunted
        new_packet();
        load_range(0, 0, PKT - 1);
        for (int k = 0; k < 5; k++) ch_q[2].push_back(junk[k]);
        new_packet();
        load_range(2, 0, PKT - 1);
        release_rst();
        run_until_empty("hunting", 2 * (PKT + 1) + 50, 1'b0);
        tick();
        n_cmp++;
        if (s_drop !== (64'd5 << 32)) begin
            n_bad++;
            $display("FAIL hunt_drop_cnt: got %h want %h", s_drop, 64'd5 << 32);
        end
    endtask

    task automatic test_backpressure();
        reset_on();
        new_packet();
        load_range(1, 0, PKT - 1);
        chk_ready = 1'b1;
        release_rst();
        run_until_empty("backpressure", 3 * PKT, 1'b1);
        chk_ready = 1'b0;
    endtask

    task automatic test_stall();
        reset_on();
        new_packet();
        load_range(1, 0, 49);
`ifdef ARB_TIMEOUT_EN
        begin
            beat_t b;
            new_packet();
            load_range(2, 0, PKT - 1);
            release_rst();
            run_until_empty("timeout", PKT + TO + 100, 1'b0);
            n_cmp++; if (abort_cnt != 1) begin n_bad++; $display("FAIL abort_count: got %0d want 1", abort_cnt); end
            n_cmp++; if (abort_gap != TO) begin n_bad++; $display("FAIL abort_gap: got %0d want %0d", abort_gap, TO); end
        end
`else
        release_rst();
        run_until_empty("stall_head", 100, 1'b0);
        for (int k = 0; k < 40; k++) tick();
        n_cmp++; if (abort_cnt != 0)      begin n_bad++; $display("FAIL stall_abort: got %0d pulses want 0", abort_cnt); end
        n_cmp++; if (s_in_ready !== 4'b0010) begin n_bad++; $display("FAIL stall_hold_ready: got %b want 0010", s_in_ready); end
        n_cmp++; if (s_chan !== 2'd1)     begin n_bad++; $display("FAIL stall_hold_chan: got %0d want 1", s_chan); end
        load_range(1, 50, PKT - 1);
        drive_inputs();
        run_until_empty("stall_tail", 300, 1'b0);
`endif
    endtask

    task automatic test_reset_mid_packet();
        int target;
        int n;
        reset_on();
        new_packet();
        load_range(2, 0, PKT - 1);
        release_rst();
        target = fire_total + 100;
        n = 0;
        while (fire_total < target && n < 300) begin
            tick();
            n++;
        end
        n_cmp++;
        if (fire_total < target) begin
            n_bad++;
            $display("FAIL midrst_progress: got %0d bytes want 100", 100 - (target - fire_total));
        end
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({s_valid, s_sop, s_eop, s_abort, s_in_ready, s_chan, s_data, s_drop} !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: valid=%b sop=%b eop=%b abort=%b in_ready=%b chan=%0d data=%02h drop=%h, want all 0",
                     s_valid, s_sop, s_eop, s_abort, s_in_ready, s_chan, s_data, s_drop);
        end
        for (int i = 0; i < 4; i++) ch_q[i].delete();
        sb.delete();
        new_packet();
        load_range(0, 0, PKT - 1);
        new_packet();
        load_range(1, 0, PKT - 1);
        release_rst();
        run_until_empty("midrst_after", 2 * (PKT + 1) + 50, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_hunting();
        test_backpressure();
        test_stall();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
